pipe_stage_fifo: RTL
====================

// Module: pipe_stage_fifo
// PURPOSE
//  Parametrised elastic inter-stage buffer for the RV32S pipeline (ID->EX, EX->ME, ...).
//  Holds up to DEPTH bundles of DATA_W bits (opcode/funct fields, rd, npc, res_R/F/M, rs2_*).
//  Uses the valid/ready protocol. ready depends only on local occupancy, so the combinational
//  ready chain is cut between stages. Supports a synchronous flush for branch redirect.
// PARAMETERS
//  DATA_W  600  width of one stage bundle in bits
//  DEPTH   2    number of entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  up_valid   in   1       upstream stage has a bundle
//  up_data    in   DATA_W  upstream bundle
//  ready      out  1       this stage accepts a bundle this cycle
//  valid      out  1       head bundle is presented downstream
//  data       out  DATA_W  head bundle
//  dn_ready   in   1       downstream accepts the head this cycle
//  flush      in   1       discard all contents (synchronous)
//  count      out  CNT_W   current occupancy
//  stall_cnt  out  32      cycles with valid=1 and dn_ready=0, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, rd/wr pointers=0, valid=0, ready=1, data=0, stall_cnt=0.
//    Storage array is not reset. Asserting reset mid-transfer drops all entries immediately.
//  - push = up_valid & ready & ~flush; pop = valid & dn_ready & ~flush.
//  - ready = (count != DEPTH). Registered state only; never depends on dn_ready or up_valid.
//  - valid = (count != 0). data = mem[rd_ptr] when valid, else all-zero.
//  - push: mem[wr_ptr] <= up_data; wr_ptr <= wr_ptr+1 (mod DEPTH).
//  - pop: rd_ptr <= rd_ptr+1 (mod DEPTH).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//    Pointers wrap silently at DEPTH-1 -> 0.
//  - Full (count=DEPTH): ready=0 even if dn_ready=1 the same cycle.
//    No push-through when full; ready rises the cycle after a pop.
//  - Empty (count=0): valid=0; dn_ready is ignored.
//  - flush=1: next edge sets count=0 and pointers=0. Flush overrides push and pop in the
//    same cycle: the incoming bundle is discarded and no pop is signalled.
//  - stall_cnt: +1 each cycle with valid & ~dn_ready & ~flush. Holds at 32'hFFFF_FFFF.
//    Cleared only by reset.
//  - Latency: minimum 1 cycle from accepted push to valid (without bypass).
//    Sustained throughput is 1 bundle/cycle when dn_ready=1.
//  - Ordering is strict FIFO; bundles are never duplicated or reordered.
// CONFIGURATION
//  PIPE_STAGE_BYPASS_EN defined:
//    - When count=0, up_valid=1, dn_ready=1 and flush=0, then valid=1 and data=up_data
//      combinationally. The bundle is not enqueued and count stays 0 (zero-latency pass).
//    - ready is unchanged (still occupancy-only).
//    - If dn_ready=0 while empty, the bundle is enqueued normally.
//  PIPE_STAGE_BYPASS_EN undefined:
//    - valid/data come only from storage; fixed 1-cycle minimum latency as above.
// TESTING
//  1. Reset: hold rst=0 with random inputs -> valid=0, ready=1, count=0, data=0, stall_cnt=0.
//  2. Streaming: DEPTH=2, dn_ready=1, push 0x1,0x2,0x3 on consecutive cycles
//     -> data 0x1,0x2,0x3 on consecutive cycles starting 1 cycle later, count never >1.
//  3. Fill/back-pressure: dn_ready=0, push A,B -> count=2, ready=0; a 3rd up_valid is not
//     taken; raise dn_ready for 1 cycle -> A out, ready=1 next cycle, then B at head.
//  4. Flush with push: count=1 (A), assert flush with up_valid=1 (C)
//     -> next cycle count=0, valid=0; C is never emitted.
//  5. Wrap-around: DEPTH=4, push 10 bundles with random dn_ready -> output order 0..9
//     exactly; pointers wrap twice with no loss.
//  6. Stall counter / bypass: valid=1, dn_ready=0 for 5 cycles -> stall_cnt=5.
//     With PIPE_STAGE_BYPASS_EN, empty + up_valid=1 + dn_ready=1 -> valid=1, data=up_data
//     in the same cycle, count stays 0.

Source files
------------

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready bundle between two RV32S pipeline stages, with flush and occupancy/stall status.
// master drives the upstream bundle, downstream ready and flush; slave is the stage buffer.
interface pipe_stage_fifo_if #(
  parameter int DATA_W = 600,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
);
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              dn_ready;
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic [31:0]       stall_cnt;

  modport master (
    output up_valid, up_data, dn_ready, flush,
    input  ready, valid, data, count, stall_cnt
  );

  modport slave (
    input  up_valid, up_data, dn_ready, flush,
    output ready, valid, data, count, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry inter-stage FIFO; 1-cycle push-to-valid (0 with PIPE_STAGE_BYPASS_EN when empty).
// ready is occupancy-only (no push-through when full); synchronous flush drops everything.
module pipe_stage_fifo #(
  parameter int DATA_W = 600,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       stall_q;
  logic              not_empty;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              stall_inc;

  assign not_empty = (count_q != '0);

`ifdef PIPE_STAGE_BYPASS_EN
  // Gated by rst so the combinational pass cannot raise valid while held in reset.
  assign bypass = rst & ~not_empty & bus.up_valid & bus.dn_ready & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.ready     = (count_q != FULL);
  assign bus.valid     = not_empty | bypass;
  assign bus.count     = count_q;
  assign bus.stall_cnt = stall_q;

  assign push      = bus.up_valid & bus.ready & ~bus.flush & ~bypass;
  assign pop       = not_empty & bus.dn_ready & ~bus.flush;
  assign stall_inc = bus.valid & ~bus.dn_ready & ~bus.flush;

  always_comb begin
    bus.data = '0;
    if (bypass) begin
      bus.data = bus.up_data;
    end else if (not_empty) begin
      bus.data = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.up_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
      if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
endmodule
